// File: rtl/bcd_updown_counter_n.sv
// Multi-digit BCD up/down counter with synchronous load, count enable,
// wrap or saturate at the limits, a wrap pulse and a load-error pulse.
// Each digit has its own increment/decrement logic. A carry/borrow chain
// runs through the digits and is built in one combinational pass.
module bcd_updown_counter_n #(
  parameter int DIGITS   = 4,
  parameter int SATURATE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic                  load_err,
  output logic                  at_max,
  output logic                  at_min
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]      r_count;
  logic              r_wrap;
  logic              r_load_err;

  logic [W-1:0]      w_inc;
  logic [W-1:0]      w_dec;
  logic [W-1:0]      w_load_clean;
  logic [DIGITS:0]   w_cy;
  logic [DIGITS:0]   w_bw;
  logic [DIGITS-1:0] w_bad;
  logic [DIGITS-1:0] w_is9;
  logic [DIGITS-1:0] w_is0;

  // A digit takes part in a step only when every lower digit is at its limit.
  // Because of that, the final carry (or borrow) also flags all-9s (or all-0s).
  assign w_cy[0] = 1'b1;
  assign w_bw[0] = 1'b1;

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      logic [3:0] w_d;
      logic [3:0] w_ld;

      assign w_d      = r_count[4*g +: 4];
      assign w_is9[g] = (w_d == 4'd9);
      assign w_is0[g] = (w_d == 4'd0);
      assign w_cy[g+1] = w_cy[g] & w_is9[g];
      assign w_bw[g+1] = w_bw[g] & w_is0[g];

      assign w_inc[4*g +: 4] = !w_cy[g] ? w_d : (w_is9[g] ? 4'd0 : w_d + 4'd1);
      assign w_dec[4*g +: 4] = !w_bw[g] ? w_d : (w_is0[g] ? 4'd9 : w_d - 4'd1);

      // A non-decimal digit (A-F) is loaded as 0, so the count stays pure BCD.
      assign w_ld                   = load_val[4*g +: 4];
      assign w_bad[g]               = (w_ld > 4'd9);
      assign w_load_clean[4*g +: 4] = w_bad[g] ? 4'd0 : w_ld;
    end
  endgenerate

  assign at_max   = w_cy[DIGITS];
  assign at_min   = w_bw[DIGITS];
  assign count    = r_count;
  assign wrap     = r_wrap;
  assign load_err = r_load_err;

  // Update the count register. Priority is rst, then load, then en.
  // Both pulses default to 0 on every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
      if (load) begin
        r_count    <= w_load_clean;
        r_load_err <= |w_bad;
      end else if (en) begin
        if (up) begin
          if (at_max) begin
            r_wrap <= 1'b1;
            if (SATURATE == 0) r_count <= w_inc;
          end else begin
            r_count <= w_inc;
          end
        end else begin
          if (at_min) begin
            r_wrap <= 1'b1;
            if (SATURATE == 0) r_count <= w_dec;
          end else begin
            r_count <= w_dec;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Self-checking bench for bcd_updown_counter_n. It instantiates four
// configurations: (4 digits, wrap), (4 digits, saturate), (1 digit, wrap)
// and (8 digits, saturate). All four are compared against a decimal-integer model.
module tb_bcd_updown_counter_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, up, load;
  logic [31:0] lv;

  logic [15:0] cnt_a, cnt_b;
  logic [3:0]  cnt_c;
  logic [31:0] cnt_d;
  logic [3:0]  wr, le, amx, amn;

  bcd_updown_counter_n #(.DIGITS(4), .SATURATE(0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv[15:0]),
    .count(cnt_a), .wrap(wr[0]), .load_err(le[0]), .at_max(amx[0]), .at_min(amn[0]));
  bcd_updown_counter_n #(.DIGITS(4), .SATURATE(1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv[15:0]),
    .count(cnt_b), .wrap(wr[1]), .load_err(le[1]), .at_max(amx[1]), .at_min(amn[1]));
  bcd_updown_counter_n #(.DIGITS(1), .SATURATE(0)) dut_c (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv[3:0]),
    .count(cnt_c), .wrap(wr[2]), .load_err(le[2]), .at_max(amx[2]), .at_min(amn[2]));
  bcd_updown_counter_n #(.DIGITS(8), .SATURATE(1)) dut_d (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv),
    .count(cnt_d), .wrap(wr[3]), .load_err(le[3]), .at_max(amx[3]), .at_min(amn[3]));

  int n_total = 0;
  int n_bad   = 0;

  int     dig[4] = '{4, 4, 1, 8};
  int     sat[4] = '{0, 1, 0, 1};
  longint m_val[4];
  logic   m_wrap[4];
  logic   m_err[4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_cnt(input int k);
    case (k)
      0:       return {16'h0, cnt_a};
      1:       return {16'h0, cnt_b};
      2:       return {28'h0, cnt_c};
      default: return cnt_d;
    endcase
  endfunction

  function automatic longint pow10(input int d);
    longint p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [31:0] to_bcd(input longint v);
    logic [31:0] r = '0;
    longint      t = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model(input int k, input logic r, input logic l, input logic e,
                       input logic u, input logic [31:0] v);
    longint mx;
    longint acc;
    int     dg;
    mx = pow10(dig[k]) - 1;
    m_wrap[k] = 1'b0;
    m_err[k]  = 1'b0;
    if (r) begin
      m_val[k] = 0;
    end else if (l) begin
      acc = 0;
      for (int i = dig[k] - 1; i >= 0; i--) begin
        dg = int'(v[4*i +: 4]);
        if (dg > 9) begin
          dg = 0;
          m_err[k] = 1'b1;
        end
        acc = acc * 10 + dg;
      end
      m_val[k] = acc;
    end else if (e) begin
      if (u) begin
        if (m_val[k] == mx) begin
          m_wrap[k] = 1'b1;
          m_val[k]  = (sat[k] != 0) ? mx : 0;
        end else begin
          m_val[k] = m_val[k] + 1;
        end
      end else begin
        if (m_val[k] == 0) begin
          m_wrap[k] = 1'b1;
          m_val[k]  = (sat[k] != 0) ? 0 : mx;
        end else begin
          m_val[k] = m_val[k] - 1;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic l, input logic e, input logic u,
                      input logic [31:0] v);
    logic [31:0] c;
    logic        ok;
    rst = r; load = l; en = e; up = u; lv = v;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      model(k, r, l, e, u, v);
      c  = get_cnt(k);
      ok = 1'b1;
      for (int i = 0; i < dig[k]; i++) if (c[4*i +: 4] > 4'd9) ok = 1'b0;
      chk($sformatf("count%0d", k), c, to_bcd(m_val[k]));
      chk($sformatf("wrap%0d", k), wr[k], m_wrap[k]);
      chk($sformatf("load_err%0d", k), le[k], m_err[k]);
      chk($sformatf("at_max%0d", k), amx[k], m_val[k] == pow10(dig[k]) - 1);
      chk($sformatf("at_min%0d", k), amn[k], m_val[k] == 0);
      chk($sformatf("bcd_digits%0d", k), ok, 1'b1);
    end
  endtask

  initial begin
    logic        r, l, e, u;
    logic [31:0] v;
    int          sel;
    rst = 1'b1; load = 1'b0; en = 1'b0; up = 1'b0; lv = '0;
    for (int k = 0; k < 4; k++) begin
      m_val[k] = 0; m_wrap[k] = 1'b0; m_err[k] = 1'b0;
    end

    step(1, 0, 0, 0, 0);
    chk("reset_count", cnt_a, 64'h0);
    chk("reset_at_min", amn[0], 1);

    // Reset while counting from 0x0347
    step(0, 1, 0, 1, 32'h0347);
    step(0, 0, 1, 1, 0);
    chk("t1_pre", cnt_a, 64'h0348);
    step(1, 0, 1, 1, 0);
    step(1, 0, 1, 1, 0);
    chk("t1_count", cnt_a, 64'h0);
    chk("t1_wrap", wr[0], 0);
    chk("t1_lerr", le[0], 0);
    chk("t1_at_min", amn[0], 1);

    // Carry ripples across several digits
    step(0, 1, 0, 1, 32'h0999);
    step(0, 0, 1, 1, 0);
    chk("t2_c1", cnt_a, 64'h1000);
    chk("t2_w1", wr[0], 0);
    step(0, 0, 1, 1, 0);
    chk("t2_c2", cnt_a, 64'h1001);
    chk("t2_w2", wr[0], 0);

    // Wrap at the top, then wrap at the bottom
    step(0, 1, 0, 1, 32'h9999);
    step(0, 0, 1, 1, 0);
    chk("t3_c_up", cnt_a, 64'h0);
    chk("t3_w_up", wr[0], 1);
    chk("t3_sat_hold", cnt_b, 64'h9999);
    chk("t3_sat_wrap", wr[1], 1);
    step(0, 0, 0, 1, 0);
    chk("t3_w_pulse", wr[0], 0);
    step(0, 0, 1, 0, 0);
    chk("t3_c_dn", cnt_a, 64'h9999);
    chk("t3_w_dn", wr[0], 1);

    // Saturate at zero for three cycles
    step(0, 1, 0, 0, 32'h0000);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 0);
      chk("t4_c", cnt_b, 64'h0);
      chk("t4_w", wr[1], 1);
    end

    // Non-BCD digits become 0; en is ignored during a load
    step(0, 1, 1, 1, 32'h1A3F);
    chk("t5_c", cnt_a, 64'h1030);
    chk("t5_lerr", le[0], 1);
    chk("t5_wrap", wr[0], 0);

    // Randomized run
    for (int n = 0; n < 10000; n++) begin
      r = ($urandom % 200) == 0;
      l = ($urandom % 16) == 0;
      e = ($urandom % 4) != 0;
      u = $urandom % 2;
      sel = $urandom_range(0, 3);
      case (sel)
        0:       v = 32'h9999_9999;
        1:       v = 32'h0000_0000;
        2:       v = $urandom;
        default: v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                      4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                      4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                      4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      endcase
      step(r, l, e, u, v);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
